// File: rtl/mem_reader_pkg.sv
// Shared parameters, FSM state encoding and length clamp for the mem_reader slice.
// No logic of its own; purely declarations.
// Not applicable.
package mem_reader_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int MAX_LEN    = 64;
    localparam int LEN_W      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requested lengths above the memory depth are read as one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
    endfunction

endpackage

// File: rtl/mem_reader_oreg.sv
// Output holding register for the mem_reader byte stream.
// Latency: one cycle from load to out_valid.
// Backpressure: data/last held stable while out_valid && !out_ready; valid drops only after a handshake.
module mem_reader_oreg
    import mem_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last
);

    // Load a new beat when asked; otherwise retire the held beat once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_reader.sv
// Sequential read-out of the 64x8 register file onto a valid/ready byte stream.
// Latency: start in N -> busy from N+1, first beat from N+2; 1 byte/cycle with out_ready high.
// Backpressure: memory fetch stalls while the held beat is not taken. Optional checksum beat: MEM_READER_CSUM_EN.
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [6:0]        len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    cnt_init;
    logic                load;
    logic                load_last;
    logic [DATA_W-1:0]   load_data;

    assign mem_addr  = addr_q;
    assign load      = (state == READ) && (!out_valid || out_ready);
    assign load_last = (cnt_q == LEN_W'(1));

`ifdef MEM_READER_CSUM_EN
    logic [DATA_W-1:0] csum_q;

    // The extra trailing beat carries the checksum instead of memory data.
    assign cnt_init  = clamp_len(len) + LEN_W'(1);
    assign load_data = load_last ? csum_q : mem_data;

    // XOR of every data byte streamed by the current command.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state == IDLE && start) begin
            csum_q <= '0;
        end else if (load && !load_last) begin
            csum_q <= csum_q ^ mem_data;
        end
    end
`else
    assign cnt_init  = clamp_len(len);
    assign load_data = mem_data;
`endif

    // Command FSM with address/count tracking and registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            cnt_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (len != '0) begin
                            addr_q <= base_addr;
                            cnt_q  <= cnt_init;
                            busy   <= 1'b1;
                            state  <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (load) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (load_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_reader_oreg #(
        .DATA_W(DATA_W)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule

// File: doc/mem_reader.md
# mem_reader

Sequential read-out engine for the 64 x 8 register-file memory. A single start command with base address and length fetches bytes from the memory's combinational read port and delivers them on a valid/ready byte stream. It sits between the memory and any downstream consumer (UART transmitter, display driver). It is the read-side counterpart of the memory's write port.

## Interface
- ADDR_W, 6, memory address width (64 locations)
- DATA_W, 8, byte width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first address to read; captured with start
- len  in  7  byte count; 0..64 legal; 65..127 treated as 64; captured with start
- mem_addr  out  ADDR_W  address to memory read port
- mem_data  in  DATA_W  memory read data; combinational from mem_addr
- out_data  out  DATA_W  stream byte
- out_valid  out  1  stream byte valid
- out_ready  in  1  consumer ready
- out_last  out  1  marks final byte of the command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 with len!=0 captures base_addr into addr_q and min(len,64) into cnt_q, then goes to READ. start=1 with len=0 goes directly to DONE; no stream beat is produced.
- READ: mem_addr=addr_q. The output register loads when it is empty or its byte is being taken (!out_valid || out_ready). On load: out_data<=mem_data, out_valid<=1, addr_q<=addr_q+1 mod 64, cnt_q<=cnt_q-1. out_last<=1 when cnt_q==1. Goes to DRAIN after the last load.
- DRAIN: holds the final beat until out_valid && out_ready, then clears out_valid and goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Address wrap: base_addr+len>64 wraps to 0. Example: base 62, len 4 reads 62, 63, 0, 1.
- Stream rules: out_data and out_last are stable while out_valid && !out_ready. out_valid never drops without a handshake.
- start while busy is ignored; there is no queueing.
- Memory writes during a command are not blocked. Each byte reflects memory content at its load edge.
- mem_addr=addr_q in every state; it is a don't-care outside READ.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, mem_addr=0. FSM=IDLE, cnt_q=0.
- rst mid-command aborts it. The pending beat is dropped and no done is issued.
- start in cycle N leads to: busy=1 from N+1, first out_valid from N+2.
- Throughput is 1 byte/cycle with out_ready held high.
- Final handshake in cycle M leads to done=1 in M+1 with busy=0 in M+1.
- len=0 start in cycle N gives done=1 in N+1; busy stays 0.
- Back-to-back: the earliest accepted start is the cycle after done.

## Configuration
- Macro: MEM_READER_CSUM_EN.
- Defined: cnt_q is loaded with n+1, and one extra beat follows the data. That beat carries the 8-bit XOR of all streamed data bytes. out_last moves to the checksum beat. For len=0, no beat is produced (unchanged).
- Undefined: no checksum register and no extra beat; behaviour is exactly as above.

## Structure
- Package mem_reader_pkg holds the ADDR_W and DATA_W defaults, MAX_LEN=64, and the FSM state enum.
- One sub-module, mem_reader_oreg, is the output holding register. It takes the load enable, data, and last flag, and implements the valid/ready stability rule.
- The FSM, address/count registers and checksum stay in mem_reader.

## Test plan
- Memory preloaded mem[i]=i+8'h10; start, base 0, len 4, out_ready=1 -> bytes 10,11,12,13 on consecutive cycles from N+2; out_last on 13; done at final handshake +1.
- base 62, len 4 -> bytes from addresses 62, 63, 0, 1 in order; mem_addr wraps to 0.
- len 3, out_ready toggled 1,0,0,1,... -> out_data/out_last stable while stalled; exactly 3 handshakes; no byte lost or repeated.
- len 0 -> no out_valid; done pulse at N+1; busy never 1. len 100 -> exactly 64 beats.
- rst asserted mid-stream after 2 of 5 beats -> next cycle all outputs 0, FSM IDLE, no done; a fresh start then works normally.
- With MEM_READER_CSUM_EN, data 01,02,04 -> beats 01,02,04,07; out_last only on 07.
